// File: rtl/mul_share_ctrl_pkg.sv
// Shared types for the two-requester multiplier controller: state encoding and default width.
// No logic; imported by the interface, the controller and the bench.
package mul_share_ctrl_pkg;

    localparam int W_DEFAULT = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_LDA,
        S_LDB,
        S_ADD,
        S_DONE
    } state_t;

endpackage

// File: rtl/mul_share_ctrl_if.sv
// Requester/datapath bundle seen by the controller; master = requesters plus datapath, slave = controller.
// Plain wires, no timing of its own.
interface mul_share_ctrl_if
    import mul_share_ctrl_pkg::*;
#(
    parameter int W = W_DEFAULT
);
    logic         req0;
    logic         req1;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic         eqz;
    logic [W-1:0] p;
    logic [W-1:0] data_out;
    logic         ldA;
    logic         ldB;
    logic         ldP;
    logic         clrP;
    logic         decB;
    logic         gnt0;
    logic         gnt1;
    logic         done0;
    logic         done1;
    logic [W-1:0] res;
    logic         busy;

    modport master (
        output req0, req1, a0, b0, a1, b1, eqz, p,
        input  data_out, ldA, ldB, ldP, clrP, decB,
        input  gnt0, gnt1, done0, done1, res, busy
    );

    modport slave (
        input  req0, req1, a0, b0, a1, b1, eqz, p,
        output data_out, ldA, ldB, ldP, clrP, decB,
        output gnt0, gnt1, done0, done1, res, busy
    );

endinterface

// File: rtl/mul_share_ctrl_rr_arb2.sv
// Two-way round-robin pick with a last-served pointer; sel is combinational, pointer moves on update.
// Reset leaves the pointer at requester 1 so requester 0 wins the first tie.
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic update,
    output logic sel
);

    logic last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (update) begin
            last_q <= sel;
        end
    end

    // A lone request wins outright; a tie goes to whoever was not served last.
    always_comb begin
        sel = req1;
        if (req0 && req1) begin
            sel = ~last_q;
        end
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one repeated-addition multiplier between two requesters; a job takes bN+4 cycles ARB->DONE.
// Requests are sampled only in IDLE; a requester waits, holding req, until its done pulse.
module mul_share_ctrl
    import mul_share_ctrl_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input logic            clk,
    input logic            rst_n,
    mul_share_ctrl_if.slave bus
);

    state_t       state_q, state_d;
    logic         sel_q, sel_d;
    logic [W-1:0] res_q, res_d;

    logic         arb_req0, arb_req1, arb_sel, arb_upd;
    logic [W-1:0] dout;
    logic         ld_a, ld_b, ld_p, clr_p, dec_b;
    logic         busy;

    // Outside IDLE the arbiter only sees the served requester, so its pointer
    // records that requester even if the live request lines have moved on.
    assign arb_req0 = (state_q == S_IDLE) ? bus.req0 : ~sel_q;
    assign arb_req1 = (state_q == S_IDLE) ? bus.req1 :  sel_q;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req0   (arb_req0),
        .req1   (arb_req1),
        .update (arb_upd),
        .sel    (arb_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        res_d   = res_q;
        dout    = '0;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        ld_p    = 1'b0;
        clr_p   = 1'b0;
        dec_b   = 1'b0;
        arb_upd = 1'b0;
        busy    = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d = S_ARB;
                    sel_d   = arb_sel;
                end
            end
            S_ARB: begin
                state_d = S_LDA;
            end
            S_LDA: begin
                dout    = sel_q ? bus.a1 : bus.a0;
                ld_a    = 1'b1;
                state_d = S_LDB;
            end
            S_LDB: begin
                dout    = sel_q ? bus.b1 : bus.b0;
                ld_b    = 1'b1;
                clr_p   = 1'b1;
                state_d = S_ADD;
            end
            S_ADD: begin
                if (!bus.eqz) begin
                    ld_p  = 1'b1;
                    dec_b = 1'b1;
                end else begin
                    state_d = S_DONE;
                    res_d   = bus.p;
                end
            end
            S_DONE: begin
                arb_upd = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.data_out = dout;
    assign bus.ldA      = ld_a;
    assign bus.ldB      = ld_b;
    assign bus.ldP      = ld_p;
    assign bus.clrP     = clr_p;
    assign bus.decB     = dec_b;
    assign bus.gnt0     = busy && !sel_q;
    assign bus.gnt1     = busy &&  sel_q;
    assign bus.done0    = (state_q == S_DONE) && !sel_q;
    assign bus.done1    = (state_q == S_DONE) &&  sel_q;
    assign bus.res      = res_q;
    assign bus.busy     = busy;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Controller plus a behavioural repeated-addition datapath; scoreboard of a*b mod 2^16 per requester,
// with round-robin order, latency and strobe counts checked by a monitor on the falling edge.
module tb_mul_share_ctrl;
    import mul_share_ctrl_pkg::*;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] prod;
    } job_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_share_ctrl_if #(.W(W)) bus ();

    mul_share_ctrl #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic         r0 = 1'b0, r1 = 1'b0;
    logic [W-1:0] ra0 = '0, rb0 = '0, ra1 = '0, rb1 = '0;
    assign bus.req0 = r0;
    assign bus.req1 = r1;
    assign bus.a0   = ra0;
    assign bus.b0   = rb0;
    assign bus.a1   = ra1;
    assign bus.b1   = rb1;

    // Datapath the controller drives: A, B (count-down) and accumulating P.
    logic [W-1:0] dp_a, dp_b, dp_p;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_a <= '0;
            dp_b <= '0;
            dp_p <= '0;
        end else begin
            if (bus.ldA) dp_a <= bus.data_out;
            if (bus.ldB) dp_b <= bus.data_out;
            else if (bus.decB) dp_b <= dp_b - 1'b1;
            if (bus.clrP) dp_p <= '0;
            else if (bus.ldP) dp_p <= dp_p + dp_a;
        end
    end
    assign bus.eqz = (dp_b == '0);
    assign bus.p   = dp_p;

    int   checks   = 0;
    int   failures = 0;
    job_t q0[$];
    job_t q1[$];

    task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Issue one job for requester n and hold req until its done pulse (or a bound expires).
    task automatic run_job(input bit n, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int drop_after);
        job_t j;
        bit   seen;
        j.a    = a;
        j.b    = b;
        j.prod = a * b;
        if (n) begin
            ra1 = a; rb1 = b; q1.push_back(j); r1 = 1'b1;
        end else begin
            ra0 = a; rb0 = b; q0.push_back(j); r0 = 1'b1;
        end
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (drop_after > 0 && k + 1 == drop_after) begin
                if (n) r1 = 1'b0; else r0 = 1'b0;
            end
            if (n ? bus.done1 : bus.done0) seen = 1'b1;
        end
        if (n) r1 = 1'b0; else r0 = 1'b0;
        if (!seen) begin
            chk(1'b0, "done_timeout", 0, 1);
            if (n && q1.size() > 0) void'(q1.pop_back());
            if (!n && q0.size() > 0) void'(q0.pop_back());
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(1);
    endtask

    // Monitor state
    int           cyc = 0;
    bit           in_job = 1'b0, prev_busy = 1'b0, win_vld = 1'b0;
    bit           cur = 1'b0, win = 1'b0, last_m = 1'b1;
    int           start = 0, nldp = 0;
    logic [W-1:0] last_res_m = '0;

    initial begin
        fork
            forever begin : monitor
                job_t j;
                @(negedge clk);
                cyc++;
                if (!rst_n) begin
                    in_job = 1'b0; prev_busy = 1'b0; win_vld = 1'b0;
                    last_m = 1'b1; last_res_m = '0;
                end else begin
                    if (bus.busy && !prev_busy) begin
                        chk(win_vld, "start_without_req", 1, 0);
                        cur = win; in_job = 1'b1; start = cyc; nldp = 0;
                    end
                    if (in_job) begin
                        chk(bus.gnt0 == !cur && bus.gnt1 == cur, "gnt",
                            {bus.gnt1, bus.gnt0}, cur ? 2 : 1);
                        if (bus.ldP) nldp++;
                        if (bus.ldA) chk(bus.data_out == (cur ? ra1 : ra0), "data_out_a",
                                         bus.data_out, cur ? ra1 : ra0);
                        if (bus.ldB) chk(bus.data_out == (cur ? rb1 : rb0), "data_out_b",
                                         bus.data_out, cur ? rb1 : rb0);
                        if (bus.done0 || bus.done1) begin
                            chk(bus.done0 == !cur && bus.done1 == cur, "done_sel",
                                {bus.done1, bus.done0}, cur ? 2 : 1);
                            if ((cur ? q1.size() : q0.size()) == 0) begin
                                chk(1'b0, "unexpected_done", 1, 0);
                            end else begin
                                j = cur ? q1.pop_front() : q0.pop_front();
                                chk(bus.res == j.prod, "res", bus.res, j.prod);
                                chk(cyc - start == int'(j.b) + 4, "latency",
                                    cyc - start, int'(j.b) + 4);
                                chk(nldp == int'(j.b), "ldp_count", nldp, j.b);
                                last_res_m = j.prod;
                            end
                            last_m = cur;
                            in_job = 1'b0;
                        end
                    end else if (bus.done0 || bus.done1) begin
                        chk(1'b0, "done_outside_job", 1, 0);
                    end
                    if (!bus.busy) begin
                        chk(bus.data_out == '0 && !bus.ldA && !bus.ldB && !bus.ldP && !bus.clrP
                            && !bus.decB && !bus.gnt0 && !bus.gnt1 && !bus.done0 && !bus.done1
                            && bus.res == last_res_m, "idle_outputs", bus.res, last_res_m);
                        // Next winner: a tie goes to the requester not served last.
                        win_vld = r0 || r1;
                        if (r0 && r1) win = (last_m == 1'b0);
                        else          win = r1;
                    end
                    prev_busy = bus.busy;
                end
            end
            begin : watchdog
                #2ms;
                $display("FAIL watchdog: simulation did not finish in time");
                $fatal(1, "watchdog");
            end
        join_none

        #1;
        chk(!bus.busy && !bus.gnt0 && !bus.gnt1 && !bus.done0 && !bus.done1 && bus.res == '0
            && bus.data_out == '0 && !bus.ldA && !bus.ldB && !bus.ldP && !bus.clrP && !bus.decB,
            "reset_outputs", bus.res, 0);
        idle_cycles(3);
        rst_n = 1'b1;
        idle_cycles(2);

        run_job(1'b0, 16'd17, 16'd5, 0);
        chk(bus.res == 16'd85, "res_17x5", bus.res, 85);
        idle_cycles(2);

        do_reset();
        fork
            run_job(1'b0, 16'd3, 16'd4, 0);
            run_job(1'b1, 16'd6, 16'd2, 0);
        join
        idle_cycles(1);
        run_job(1'b0, 16'd5, 16'd5, 0);
        fork
            run_job(1'b0, 16'd2, 16'd3, 0);
            run_job(1'b1, 16'd4, 16'd4, 0);
        join
        idle_cycles(2);

        run_job(1'b1, 16'd99, 16'd0, 0);
        chk(bus.res == 16'd0, "res_b_zero", bus.res, 0);
        idle_cycles(1);
        run_job(1'b0, 16'd0, 16'd7, 0);
        idle_cycles(1);
        run_job(1'b0, 16'd300, 16'd300, 0);
        chk(bus.res == 16'd24464, "res_overflow", bus.res, 24464);
        idle_cycles(2);

        // Reset in the middle of ADD: everything drops at once and no done appears.
        ra0 = 16'd1234; rb0 = 16'd30; r0 = 1'b1;
        for (int k = 0; k < 20 && !bus.busy; k++) idle_cycles(1);
        chk(bus.busy, "reset_job_started", bus.busy, 1);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk(!bus.busy && !bus.gnt0 && !bus.gnt1 && !bus.done0 && !bus.done1 && bus.res == '0
            && bus.data_out == '0 && !bus.ldA && !bus.ldB && !bus.ldP && !bus.clrP && !bus.decB,
            "midjob_reset_outputs", bus.res, 0);
        r0 = 1'b0;
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(3);
        chk(!bus.busy, "idle_after_reset", bus.busy, 0);
        run_job(1'b0, 16'd1234, 16'd30, 0);
        idle_cycles(1);

        run_job(1'b1, 16'd7, 16'd6, 4);
        chk(bus.res == 16'd42, "res_req_dropped", bus.res, 42);
        idle_cycles(2);

        fork
            for (int i = 0; i < 8; i++) begin
                run_job(1'b0, W'($urandom), W'($urandom_range(0, 12)), 0);
                idle_cycles($urandom_range(0, 3));
            end
            for (int i = 0; i < 8; i++) begin
                run_job(1'b1, W'($urandom), W'($urandom_range(0, 12)), 0);
                idle_cycles($urandom_range(0, 3));
            end
        join
        idle_cycles(4);
        chk(q0.size() == 0 && q1.size() == 0, "scoreboard_drained", q0.size() + q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_share_ctrl.md
MUL_SHARE_CTRL -- requirements
Module: mul_share_ctrl

Interface
REQ-001 SHALL use parameter W, default 16, meaning the operand, product and data-bus width.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports req0/req1, input, 1 each, a job request per requester, held high until that requester's done pulse.
REQ-005 SHALL have ports a0/b0 and a1/b1, input, W each, the operands, held stable by the requester while reqN is high.
REQ-006 SHALL have port eqz, input, 1, the datapath flag, high when the datapath B register is zero.
REQ-007 SHALL have port p, input, W, the datapath product register value.
REQ-008 SHALL have port data_out, output, W, the operand bus to the datapath data_in.
REQ-009 SHALL have ports ldA, ldB, ldP, clrP and decB, output, 1 each, the datapath strobes.
REQ-010 SHALL have ports gnt0/gnt1, output, 1 each, one-hot grant, high from ARB through DONE for the served requester.
REQ-011 SHALL have ports done0/done1, output, 1 each, a one-cycle completion pulse.
REQ-012 SHALL have port res, output, W, the product, valid while doneN is high and held until the next DONE.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-014 SHALL implement the states IDLE, ARB, LDA, LDB, ADD and DONE.
REQ-015 IDLE SHALL go to ARB when req0|req1 is high, else stay in IDLE.
REQ-016 ARB SHALL select the requester and assert its gnt, then go to LDA.
REQ-017 LDA SHALL drive data_out=aN and ldA=1, then go to LDB.
REQ-018 LDB SHALL drive data_out=bN, ldB=1 and clrP=1, then go to ADD.
REQ-019 ADD SHALL, while eqz=0, assert ldP=1 and decB=1 (Mealy, gated by !eqz) and stay in ADD; when eqz=1 it SHALL assert no strobes and go to DONE.
REQ-020 On DONE entry SHALL capture res<=p; in DONE SHALL assert the selected doneN for exactly one cycle, then go to IDLE.
REQ-021 Latency: DONE SHALL be entered exactly bN+4 cycles after ARB is entered.
REQ-022 Arbitration SHALL be round-robin with a last-served pointer: a lone request wins; on simultaneous requests the one not last served wins; the pointer updates in DONE.
REQ-023 A request arriving during a job SHALL be held pending and served via IDLE->ARB, costing one IDLE cycle between jobs.
REQ-024 Simultaneous events: req sampled only in IDLE; changes on the other requester's lines during a job SHALL be ignored.
REQ-025 bN=0 SHALL give one ADD cycle with no strobes and res=0; aN=0 SHALL give res=0 after bN+4 cycles.
REQ-026 Arithmetic SHALL be modulo 2^W (datapath truncation); overflow SHALL not be flagged.
REQ-027 If reqN drops mid-job, the job SHALL complete and doneN SHALL still pulse.
REQ-028 When not loading, data_out SHALL be 0 and all strobes SHALL be 0 outside the states named above.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, all strobes 0, gnt0/gnt1 0, done0/done1 0, res 0, data_out 0, busy 0, and the pointer favouring requester 0.
REQ-030 Reset asserted mid-job SHALL abort the job with no done pulse; after release the requester SHALL re-request.

Structure
REQ-031 A shared package SHALL hold the state enumeration and the W default.
REQ-032 The round-robin selection and pointer SHALL be one sub-module, rr_arb2 (inputs req0, req1, update; output sel).
REQ-033 The block SHALL be verified against the existing repeated-addition multiplier datapath instantiated alongside it.

Verification
REQ-034 The bench SHALL apply req0 only with a0=17, b0=5 -> gnt0 high, done0 after 9 cycles from ARB, res=85.
REQ-035 The bench SHALL apply req0 and req1 together after reset (3×4, 6×2) -> requester 0 served first (res=12), then requester 1 (res=12); then both again -> requester 1 served first.
REQ-036 The bench SHALL apply b1=0, a1=99 -> no ldP/decB pulses, res=0, done1 4 cycles after ARB.
REQ-037 The bench SHALL apply a0=300, b0=300 with W=16 -> res=90000 mod 65536=24464.
REQ-038 The bench SHALL pulse rst_n low during ADD -> outputs zero immediately, no done pulse, IDLE after release.
REQ-039 The bench SHALL drop req1 during ADD -> the job completes and done1 pulses with the correct res.
